close_tx: RTL

//  Transmit-side counterpart of the CLOSE control packet receive path. On a local close

---
 rtl/close_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/close_tx.sv
// close_tx: builds one UDT Shutdown control packet on a local close request and
// streams it as two 64-bit beats toward the control-packet mux, then reports the
// closed connection state on a valid/ready handshake.
// Build option: define CLOSE_RETX_EN to send RETX_NUM copies separated by
// RETX_GAP idle cycles; without it exactly one copy is sent.
module close_tx #(
  parameter logic [31:0] ST_CONNECTED = 32'd3,
  parameter logic [31:0] ST_CLOSED    = 32'd6,
  parameter logic [14:0] CTRL_TYPE    = 15'h0005,
  parameter int unsigned RETX_NUM     = 3,
  parameter int unsigned RETX_GAP     = 1024
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic        close_req_i,
  input  logic [31:0] udt_state_i,
  input  logic [31:0] dst_sock_id_i,
  input  logic [31:0] timestamp_i,
  output logic        close_tvalid_o,
  output logic [63:0] close_tdata_o,
  output logic [7:0]  close_tkeep_o,
  output logic        close_tlast_o,
  input  logic        close_tready_i,
  output logic [31:0] udt_state_o,
  output logic        state_valid_o,
  input  logic        state_ready_i,
  output logic        busy_o
);

  // Elaboration-time sanity check on the retransmission configuration.
  if (RETX_NUM < 1 || RETX_GAP < 1) begin : g_bad_cfg
    $error("close_tx: RETX_NUM and RETX_GAP must both be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    BEAT0,
    BEAT1,
    REPORT
`ifdef CLOSE_RETX_EN
    ,
    GAP
`endif
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] ts_q;
  logic [31:0] sock_q;
  logic        accept;

  // A request is honoured only from IDLE while the connection is up.
  assign accept = (state == IDLE) && close_req_i && (udt_state_i == ST_CONNECTED);

`ifdef CLOSE_RETX_EN
  localparam int unsigned COPY_W = $clog2(RETX_NUM + 1);
  localparam int unsigned GAP_W  = $clog2(RETX_GAP + 1);

  logic [COPY_W-1:0] copy_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              last_copy;
  logic              gap_done;

  // copy_cnt holds the number of copies already completed before the current one.
  assign last_copy = (copy_cnt == COPY_W'(RETX_NUM - 1));
  assign gap_done  = (gap_cnt == GAP_W'(RETX_GAP - 1));

  // Copy counter: cleared on acceptance, advanced at each completed copy.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      copy_cnt <= '0;
    end else if (accept) begin
      copy_cnt <= '0;
    end else if (state == BEAT1 && close_tready_i && !last_copy) begin
      copy_cnt <= copy_cnt + 1'b1;
    end
  end

  // Gap counter: runs only while idling between copies, zero otherwise.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      gap_cnt <= '0;
    end else if (state == GAP && !gap_done) begin
      gap_cnt <= gap_cnt + 1'b1;
    end else begin
      gap_cnt <= '0;
    end
  end
`endif

  // State register.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch packet fields at acceptance so later input changes cannot disturb the packet.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      ts_q   <= '0;
      sock_q <= '0;
    end else if (accept) begin
      ts_q   <= timestamp_i;
      sock_q <= dst_sock_id_i;
    end
  end

  // Next-state and output decode; outputs depend on state only, so they hold
  // stable under backpressure and clear as soon as reset forces IDLE.
  always_comb begin
    state_nxt      = state;
    close_tvalid_o = 1'b0;
    close_tdata_o  = '0;
    close_tkeep_o  = '0;
    close_tlast_o  = 1'b0;
    udt_state_o    = '0;
    state_valid_o  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = BEAT0;
      end
      BEAT0: begin
        close_tvalid_o = 1'b1;
        close_tdata_o  = {1'b1, CTRL_TYPE, 16'h0000, 32'h0000_0000};
        close_tkeep_o  = '1;
        if (close_tready_i) state_nxt = BEAT1;
      end
      BEAT1: begin
        close_tvalid_o = 1'b1;
        close_tdata_o  = {ts_q, sock_q};
        close_tkeep_o  = '1;
        close_tlast_o  = 1'b1;
        if (close_tready_i) begin
`ifdef CLOSE_RETX_EN
          state_nxt = last_copy ? REPORT : GAP;
`else
          state_nxt = REPORT;
`endif
        end
      end
`ifdef CLOSE_RETX_EN
      GAP: begin
        if (gap_done) state_nxt = BEAT0;
      end
`endif
      REPORT: begin
        udt_state_o   = ST_CLOSED;
        state_valid_o = 1'b1;
        if (state_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

endmodule
